// File: rtl/eth_tx_frame_arbiter.sv
// rtl/eth_tx_frame_arbiter.sv - frame-granular round-robin arbiter in front of the Ethernet TX header framer.
// Optional per-port frame counters: define ETH_TX_ARB_STATS_EN.
module eth_tx_frame_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 512,
    parameter int IDX_W      = $clog2(NUM_PORTS)
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
    output logic [NUM_PORTS-1:0]           s_axis_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]           s_axis_tlast,
    input  logic [NUM_PORTS*48-1:0]        s_dest_mac,
    input  logic [NUM_PORTS*16-1:0]        s_eth_type,
    input  logic [47:0]                    local_mac,
    output logic                           m_eth_hdr_valid,
    input  logic                           m_eth_hdr_ready,
    output logic [47:0]                    m_eth_dest_mac,
    output logic [47:0]                    m_eth_src_mac,
    output logic [15:0]                    m_eth_type,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]        m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic [IDX_W-1:0]               grant_idx,
`ifdef ETH_TX_ARB_STATS_EN
    input  logic                           stats_clr,
    output logic [NUM_PORTS*32-1:0]        frame_count,
`endif
    output logic                           busy
);

    localparam int KEEP_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_grant;
    logic                r_hdr_valid;
    logic [47:0]         r_dest_mac;
    logic [15:0]         r_eth_type;

    logic [IDX_W-1:0]    w_sel;
    logic [IDX_W-1:0]    w_cand;
    logic                w_req_found;
    logic                w_last_fire;

    logic [DATA_WIDTH-1:0] w_tdata_arr [NUM_PORTS];
    logic [KEEP_W-1:0]     w_tkeep_arr [NUM_PORTS];
    logic [47:0]           w_mac_arr   [NUM_PORTS];
    logic [15:0]           w_type_arr  [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign w_tdata_arr[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_tkeep_arr[gi] = s_axis_tkeep[gi*KEEP_W +: KEEP_W];
        assign w_mac_arr[gi]   = s_dest_mac[gi*48 +: 48];
        assign w_type_arr[gi]  = s_eth_type[gi*16 +: 16];
    end

    // Scan starts one past the last winner so the previous owner is considered last.
    always_comb begin
        w_sel       = r_grant;
        w_cand      = r_grant;
        w_req_found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = IDX_W'((int'(r_grant) + k) % NUM_PORTS);
            if (!w_req_found && s_axis_tvalid[w_cand]) begin
                w_req_found = 1'b1;
                w_sel       = w_cand;
            end
        end
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (r_state == ST_DATA) begin
            m_axis_tvalid          = s_axis_tvalid[r_grant];
            s_axis_tready[r_grant] = m_axis_tready;
        end
    end

    assign m_axis_tdata = w_tdata_arr[r_grant];
    assign m_axis_tkeep = w_tkeep_arr[r_grant];
    assign m_axis_tlast = s_axis_tlast[r_grant];
    assign w_last_fire  = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req_found)     w_state_nxt = ST_HDR;
            ST_HDR:  if (m_eth_hdr_ready) w_state_nxt = ST_DATA;
            ST_DATA: if (w_last_fire)     w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Header fields are captured once at grant and held for the whole frame.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_grant     <= IDX_W'(NUM_PORTS - 1);
            r_hdr_valid <= 1'b0;
            r_dest_mac  <= '0;
            r_eth_type  <= '0;
        end else if (r_state == ST_IDLE && w_req_found) begin
            r_grant     <= w_sel;
            r_hdr_valid <= 1'b1;
            r_dest_mac  <= w_mac_arr[w_sel];
            r_eth_type  <= w_type_arr[w_sel];
        end else if (r_state == ST_HDR && m_eth_hdr_ready) begin
            r_hdr_valid <= 1'b0;
        end
    end

    assign m_eth_hdr_valid = r_hdr_valid;
    assign m_eth_dest_mac  = r_dest_mac;
    assign m_eth_type      = r_eth_type;
    assign m_eth_src_mac   = local_mac;
    assign grant_idx       = r_grant;
    assign busy            = (r_state != ST_IDLE);

`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] r_frame_count [NUM_PORTS];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) r_frame_count[i] <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < NUM_PORTS; i++) r_frame_count[i] <= '0;
        end else if (w_last_fire) begin
            r_frame_count[r_grant] <= r_frame_count[r_grant] + 32'd1;
        end
    end

    for (genvar gc = 0; gc < NUM_PORTS; gc++) begin : g_cnt
        assign frame_count[gc*32 +: 32] = r_frame_count[gc];
    end
`endif

endmodule

// File: doc/eth_tx_frame_arbiter.md
Name: eth_tx_frame_arbiter

Overview:
- Shares one Ethernet TX header-insertion path (512b payload AXIS plus header handshake) between NUM_PORTS payload requesters.
- Arbitration is frame-granular round-robin. A grant is held from the header handshake until the tlast beat.
- Sits upstream of the Ethernet header framer. Each requester supplies its own destination MAC and ethertype; source MAC is common.

Parameters:
- NUM_PORTS, 2, number of requesters; legal range 2..8.
- DATA_WIDTH, 512, payload tdata width; tkeep width is DATA_WIDTH/8.
- IDX_W, $clog2(NUM_PORTS), width of grant index.

Ports:
- ap_clk  in  1  sole clock.
- ap_rst_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  NUM_PORTS  per-port payload valid.
- s_axis_tready  out  NUM_PORTS  per-port payload ready.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  per-port payload data; port i at slice i.
- s_axis_tkeep  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
- s_axis_tlast  in  NUM_PORTS  per-port end of frame.
- s_dest_mac  in  NUM_PORTS*48  per-port destination MAC.
- s_eth_type  in  NUM_PORTS*16  per-port ethertype.
- local_mac  in  48  source MAC for all frames.
- m_eth_hdr_valid  out  1  header valid to framer.
- m_eth_hdr_ready  in  1  header accepted by framer.
- m_eth_dest_mac  out  48  registered destination MAC of granted port.
- m_eth_src_mac  out  48  equals local_mac (pass-through).
- m_eth_type  out  16  registered ethertype of granted port.
- m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1  muxed payload to framer.
- grant_idx  out  IDX_W  currently or last granted port.
- busy  out  1  high in HDR or DATA.

Behaviour:
- Reset (async assert, sync release): state=IDLE; m_eth_hdr_valid=0; m_eth_dest_mac=0; m_eth_type=0; grant_idx=NUM_PORTS-1 so port 0 wins first; busy=0. Output m_axis_tvalid=0 and all s_axis_tready=0 follow combinationally from IDLE.
- FSM states: IDLE, HDR, DATA.
- IDLE, any s_axis_tvalid high:
  - Select the first requesting port scanning from grant_idx+1 upward, wrapping modulo NUM_PORTS.
  - Next edge: grant_idx <= selected; latch that port's s_dest_mac and s_eth_type; m_eth_hdr_valid <= 1; state <= HDR.
  - Latency is 1 cycle from request to header valid.
- IDLE with no request: stay.
- HDR: m_eth_hdr_valid held high and header fields held stable until m_eth_hdr_ready. On handshake, next edge clears hdr_valid and moves to DATA. No payload beats pass in HDR.
- DATA:
  - Combinational mux: m_axis_tvalid = s_axis_tvalid[grant_idx]; m_axis_tdata/tkeep/tlast from slice grant_idx.
  - s_axis_tready[grant_idx] = m_axis_tready; all other s_axis_tready = 0.
  - On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast, next edge goes to IDLE.
- Back-to-back frames: exactly one IDLE cycle between the tlast beat and the next header valid. grant_idx holds the last winner in IDLE, so round-robin resumes after it.
- Single requester: that port is re-granted each frame.
- Simultaneous requests: strict rotation. With all ports requesting continuously, the order is 0,1,...,N-1,0,...
- A requester dropping tvalid mid-frame stalls the grant; there is no preemption and no timeout.
- Header fields are sampled once at grant. Changes to s_dest_mac or s_eth_type mid-frame have no effect on that frame.
- Reset asserted mid-frame: immediate return to IDLE. The partial frame is abandoned; the downstream framer is reset by the same reset.
- busy = (state != IDLE).

Optional Feature:
- Macro ETH_TX_ARB_STATS_EN, when defined:
  - Adds output port frame_count, width NUM_PORTS*32.
  - Port i's counter increments by 1 on each tlast beat accepted from port i and wraps 0xFFFFFFFF -> 0.
  - Reset value is 0.
  - Adds input stats_clr (1): synchronous clear of all counters; clear wins over a same-cycle increment.
- Macro undefined: neither port nor counters exist; all other behaviour is identical.

Test Plan:
- Reset, then port 0 sends a 3-beat frame with dest 02:00:00:00:00:01 and type 0x88B5, hdr_ready=1.
  -> hdr_valid 1 cycle after tvalid with those fields; 3 beats out, tlast on beat 3; busy falls after tlast.
- Ports 0 and 1 both request continuously with 1-beat frames.
  -> grant_idx sequence 0,1,0,1; exactly 1 idle cycle between frames; non-granted tready stays 0.
- hdr_ready held 0 for 5 cycles.
  -> hdr_valid and fields stable for 5 cycles; no payload beat passes; DATA entered after ready rises.
- Granted port deasserts tvalid for 4 cycles mid-frame while port 1 requests.
  -> grant held, no interleaving; port 1 is served only after port 0's tlast.
- m_axis_tready toggled 1010 during a 4-beat frame.
  -> every beat delivered once in order; data/keep/last match source.
- With ETH_TX_ARB_STATS_EN: 3 frames from port 1, then stats_clr pulsed in the same cycle as a tlast beat.
  -> count[1]=3 before the clear, then 0 after it.
